// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: forwarding muxes, ALU with iterative multiply, and EX/MEM output latch
module ex_stage_pipe #(
    parameter int WORD_W     = 32,
    parameter int SHAM_W     = 5,
    parameter int REG_W      = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic [WORD_W-1:0] rdat1,
    input  logic [WORD_W-1:0] rdat2,
    input  logic [WORD_W-1:0] imm,
    input  logic [SHAM_W-1:0] shamt,
    input  logic [3:0]        aluop,
    input  logic              alusrc,
    input  logic [1:0]        fwdA_sel,
    input  logic [1:0]        fwdB_sel,
    input  logic [WORD_W-1:0] fwd_mem,
    input  logic [WORD_W-1:0] fwd_wb,
    input  logic [WORD_W-1:0] nPC,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              regWr,
    input  logic [REG_W-1:0]  regDst,
    output logic              ex_busy,
    output logic              out_valid,
    output logic [WORD_W-1:0] ALUOut,
    output logic [WORD_W-1:0] wdat,
    output logic [WORD_W-1:0] nPC_next,
    output logic              dREN_next,
    output logic              dWEN_next,
    output logic              regWr_next,
    output logic [REG_W-1:0]  regDst_next,
    output logic              overflow,
    output logic              equal
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int LUI_SH = (WORD_W >= 32) ? 16 : WORD_W / 2;
    localparam logic [WORD_W-1:0] LUI_MASK = (WORD_W >= 32) ? WORD_W'(32'hFFFF) : '1;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic {IDLE, MUL} state_t;

    state_t            r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [WORD_W-1:0] w_opa, w_fb, w_opb, w_sum, w_dif, w_res, w_prod;
    logic              w_ovf, w_start, w_done;
    logic [WORD_W-1:0] r_ma, r_mb, r_mwdat, r_mnpc;
    logic              r_mren, r_mwen, r_mwr;
    logic [REG_W-1:0]  r_mdst;

    assign w_opa   = (fwdA_sel == 2'd1) ? fwd_mem : (fwdA_sel == 2'd2) ? fwd_wb : rdat1;
    assign w_fb    = (fwdB_sel == 2'd1) ? fwd_mem : (fwdB_sel == 2'd2) ? fwd_wb : rdat2;
    assign w_opb   = alusrc ? imm : w_fb;
    assign w_sum   = w_opa + w_opb;
    assign w_dif   = w_opa - w_opb;
    assign w_prod  = r_ma * r_mb;
    assign equal   = w_opa == w_fb;
    assign w_start = r_state == IDLE && in_valid && aluop == OP_MUL;
    assign w_done  = r_state == MUL && r_cnt == '0 && !mem_stall;
    assign ex_busy = w_start || (r_state == MUL && !w_done);

    // single-cycle ALU result and ADD/SUB signed overflow
    always_comb begin
        w_res = w_sum;
        w_ovf = 1'b0;
        case (aluop)
            4'd1: begin
                w_res = w_dif;
                w_ovf = (w_opa[WORD_W-1] != w_opb[WORD_W-1]) && (w_dif[WORD_W-1] != w_opa[WORD_W-1]);
            end
            4'd2:    w_res = w_opa & w_opb;
            4'd3:    w_res = w_opa | w_opb;
            4'd4:    w_res = w_opa ^ w_opb;
            4'd5:    w_res = ~(w_opa | w_opb);
            4'd6:    w_res = {{(WORD_W-1){1'b0}}, $signed(w_opa) < $signed(w_opb)};
            4'd7:    w_res = {{(WORD_W-1){1'b0}}, w_opa < w_opb};
            4'd8:    w_res = w_opb << shamt;
            4'd9:    w_res = w_opb >> shamt;
            4'd10:   w_res = $unsigned($signed(w_opb) >>> shamt);
            4'd11:   w_res = (imm & LUI_MASK) << LUI_SH;
            default: w_ovf = (w_opa[WORD_W-1] == w_opb[WORD_W-1]) && (w_sum[WORD_W-1] != w_opa[WORD_W-1]);
        endcase
    end

    // next state: flush aborts, stall holds, multiply counts down to zero then returns to IDLE
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        if (flush) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
        end else if (!mem_stall) begin
            if (w_start) begin
                w_state_n = MUL;
                w_cnt_n   = CNT_W'(MUL_CYCLES - 1);
            end else if (r_state == MUL) begin
                w_state_n = (r_cnt == '0) ? IDLE : MUL;
                w_cnt_n   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
            end
        end
    end

    // state and iteration counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // EX/MEM latch and multiply operand capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid   <= 1'b0;
            ALUOut      <= '0;
            wdat        <= '0;
            nPC_next    <= '0;
            dREN_next   <= 1'b0;
            dWEN_next   <= 1'b0;
            regWr_next  <= 1'b0;
            regDst_next <= '0;
            overflow    <= 1'b0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_mwdat     <= '0;
            r_mnpc      <= '0;
            r_mren      <= 1'b0;
            r_mwen      <= 1'b0;
            r_mwr       <= 1'b0;
            r_mdst      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!mem_stall) begin
            if (r_state == MUL) begin
                out_valid <= r_cnt == '0;
                if (r_cnt == '0) begin
                    ALUOut      <= w_prod;
                    wdat        <= r_mwdat;
                    nPC_next    <= r_mnpc;
                    dREN_next   <= r_mren;
                    dWEN_next   <= r_mwen;
                    regWr_next  <= r_mwr;
                    regDst_next <= r_mdst;
                    overflow    <= 1'b0;
                end
            end else if (w_start) begin
                out_valid <= 1'b0;
                r_ma      <= w_opa;
                r_mb      <= w_opb;
                r_mwdat   <= w_fb;
                r_mnpc    <= nPC;
                r_mren    <= dREN;
                r_mwen    <= dWEN;
                r_mwr     <= regWr;
                r_mdst    <= regDst;
            end else if (in_valid) begin
                out_valid   <= 1'b1;
                ALUOut      <= w_res;
                wdat        <= w_fb;
                nPC_next    <= nPC;
                dREN_next   <= dREN;
                dWEN_next   <= dWEN;
                regWr_next  <= regWr;
                regDst_next <= regDst;
                overflow    <= w_ovf;
            end else begin
                out_valid  <= 1'b0;
                dREN_next  <= 1'b0;
                dWEN_next  <= 1'b0;
                regWr_next <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed vectors checked against a behavioural execute-stage model
module tb_ex_stage_pipe;
    localparam int MC = 4;

    logic        CLK, RST, in_valid, flush, mem_stall, alusrc;
    logic [31:0] rdat1, rdat2, imm, fwd_mem, fwd_wb, nPC;
    logic [4:0]  shamt, regDst;
    logic [3:0]  aluop;
    logic [1:0]  fwdA_sel, fwdB_sel;
    logic        dREN, dWEN, regWr;
    logic        ex_busy, out_valid, dREN_next, dWEN_next, regWr_next, overflow, equal;
    logic [31:0] ALUOut, wdat, nPC_next;
    logic [4:0]  regDst_next;

    int checks = 0;
    int errors = 0;

    ex_stage_pipe #(.WORD_W(32), .SHAM_W(5), .REG_W(5), .MUL_CYCLES(MC)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .flush(flush), .mem_stall(mem_stall),
        .rdat1(rdat1), .rdat2(rdat2), .imm(imm), .shamt(shamt), .aluop(aluop), .alusrc(alusrc),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
        .nPC(nPC), .dREN(dREN), .dWEN(dWEN), .regWr(regWr), .regDst(regDst),
        .ex_busy(ex_busy), .out_valid(out_valid), .ALUOut(ALUOut), .wdat(wdat),
        .nPC_next(nPC_next), .dREN_next(dREN_next), .dWEN_next(dWEN_next),
        .regWr_next(regWr_next), .regDst_next(regDst_next), .overflow(overflow), .equal(equal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] r, m, w);
        return (s == 2'd1) ? m : (s == 2'd2) ? w : r;
    endfunction

    // reference ALU: {overflow, result}
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, im,
                                            input logic [4:0] sh);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin s = sa - sb; return {s != longint'(int'(s)), a - b}; end
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, ~(a | b)};
            4'd6: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            4'd7: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'd8: return {1'b0, b << sh};
            4'd9: return {1'b0, b >> sh};
            4'd10: return {1'b0, 32'($signed(b) >>> sh)};
            4'd11: return {1'b0, im[15:0], 16'h0};
            4'd12: return {1'b0, a * b};
            default: begin s = sa + sb; return {s != longint'(int'(s)), a + b}; end
        endcase
    endfunction

    logic        m_valid = 0, m_ovf = 0, m_ren = 0, m_wen = 0, m_wr = 0;
    logic [31:0] m_alu = 0, m_wdat = 0, m_npc = 0;
    logic [4:0]  m_dst = 0;
    logic        pend = 0, p_ren = 0, p_wen = 0, p_wr = 0;
    int          left = 0;
    logic [31:0] p_alu = 0, p_wdat = 0, p_npc = 0;
    logic [4:0]  p_dst = 0;
    logic [31:0] ma, mfb, mb;
    logic [32:0] mr;

    // model: product is computed at issue, then released after MC unstalled edges
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid = 0; m_ovf = 0; m_ren = 0; m_wen = 0; m_wr = 0;
            m_alu = 0; m_wdat = 0; m_npc = 0; m_dst = 0; pend = 0; left = 0;
        end else if (flush) begin
            m_valid = 0;
            pend = 0;
        end else if (!mem_stall) begin
            if (pend) begin
                left--;
                m_valid = 0;
                if (left == 0) begin
                    pend = 0; m_valid = 1; m_alu = p_alu; m_wdat = p_wdat; m_npc = p_npc;
                    m_ren = p_ren; m_wen = p_wen; m_wr = p_wr; m_dst = p_dst; m_ovf = 0;
                end
            end else if (in_valid) begin
                ma  = fsel(fwdA_sel, rdat1, fwd_mem, fwd_wb);
                mfb = fsel(fwdB_sel, rdat2, fwd_mem, fwd_wb);
                mb  = alusrc ? imm : mfb;
                mr  = ref_alu(aluop, ma, mb, imm, shamt);
                if (aluop == 4'd12) begin
                    pend = 1; left = MC; m_valid = 0; p_alu = mr[31:0]; p_wdat = mfb;
                    p_npc = nPC; p_ren = dREN; p_wen = dWEN; p_wr = regWr; p_dst = regDst;
                end else begin
                    m_valid = 1; m_alu = mr[31:0]; m_ovf = mr[32]; m_wdat = mfb;
                    m_npc = nPC; m_ren = dREN; m_wen = dWEN; m_wr = regWr; m_dst = regDst;
                end
            end else begin
                m_valid = 0; m_ren = 0; m_wen = 0; m_wr = 0;
            end
        end
    end

    // compare on the falling edge, away from the active edge
    always @(negedge CLK) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("ex_busy", {31'b0, ex_busy},
            {31'b0, pend ? !(left == 1 && !mem_stall) : (in_valid && aluop == 4'd12)});
        chk("equal", {31'b0, equal},
            {31'b0, fsel(fwdA_sel, rdat1, fwd_mem, fwd_wb) == fsel(fwdB_sel, rdat2, fwd_mem, fwd_wb)});
        if (m_valid) begin
            chk("ALUOut", ALUOut, m_alu);
            chk("wdat", wdat, m_wdat);
            chk("nPC_next", nPC_next, m_npc);
            chk("ctrl", {29'b0, dREN_next, dWEN_next, regWr_next}, {29'b0, m_ren, m_wen, m_wr});
            chk("regDst_next", {27'b0, regDst_next}, {27'b0, m_dst});
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [3:0] op, input logic [31:0] a, b, im, input logic src,
                       input logic [4:0] sh);
        in_valid = 1; aluop = op; rdat1 = a; rdat2 = b; imm = im; alusrc = src; shamt = sh;
        fwdA_sel = 0; fwdB_sel = 0; nPC = nPC + 4; regDst = regDst + 1;
        dREN = op[0]; dWEN = op[1]; regWr = ~op[2];
    endtask

    logic [3:0] ops [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14};
    int busy_n;

    initial begin
        RST = 0; in_valid = 0; flush = 0; mem_stall = 0; alusrc = 0; rdat1 = 0; rdat2 = 0;
        imm = 0; fwd_mem = 0; fwd_wb = 0; nPC = 32'h100; shamt = 0; regDst = 0; aluop = 0;
        fwdA_sel = 0; fwdB_sel = 0; dREN = 0; dWEN = 0; regWr = 0;
        #2 RST = 1;
        step;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_alu", ALUOut, 32'd0);
        step;
        RST = 0;
        put(4'd0, 32'd5, 32'd0, 32'd3, 1'b1, 5'd0);
        fwdA_sel = 1; fwd_mem = 32'h10;
        step;
        chk("add_fwd", ALUOut, 32'h13);
        chk("add_fwd_valid", {31'b0, out_valid}, 32'd1);
        chk("add_fwd_ovf", {31'b0, overflow}, 32'd0);
        put(4'd0, 32'h7FFFFFFF, 32'd0, 32'd1, 1'b1, 5'd0);
        step;
        chk("add_ovf_res", ALUOut, 32'h80000000);
        chk("add_ovf", {31'b0, overflow}, 32'd1);
        put(4'd1, 32'h80000000, 32'd1, 32'd0, 1'b0, 5'd0);
        step;
        chk("sub_ovf_res", ALUOut, 32'h7FFFFFFF);
        chk("sub_ovf", {31'b0, overflow}, 32'd1);
        put(4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0);
        step;
        chk("slt", ALUOut, 32'd1);
        put(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0);
        step;
        chk("sltu", ALUOut, 32'd0);
        put(4'd4, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        fwdA_sel = 1; fwd_mem = 32'h1234; fwdB_sel = 2; fwd_wb = 32'h1235;
        #1 chk("equal_lo", {31'b0, equal}, 32'd0);
        fwd_wb = 32'h1234;
        #1 chk("equal_hi", {31'b0, equal}, 32'd1);
        step;
        chk("xor_eq", ALUOut, 32'd0);
        for (int i = 0; i < 10; i++) begin
            put(ops[i], 32'h0F0F1234, 32'h80000F00, 32'h0000ABCD, 1'b0, 5'd4);
            step;
            if (ops[i] == 4'd10) chk("sra", ALUOut, 32'hF80000F0);
            if (ops[i] == 4'd11) chk("lui", ALUOut, 32'hABCD0000);
        end
        in_valid = 0;
        step;
        chk("bubble_valid", {31'b0, out_valid}, 32'd0);
        chk("bubble_regwr", {31'b0, regWr_next}, 32'd0);
        put(4'd0, 32'd100, 32'd0, 32'd23, 1'b1, 5'd0);
        step;
        chk("pre_stall", ALUOut, 32'd123);
        mem_stall = 1;
        put(4'd4, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0);
        step;
        step;
        chk("stall_hold", ALUOut, 32'd123);
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        mem_stall = 0;
        step;
        chk("post_stall", ALUOut, 32'd3);
        put(4'd12, 32'd7, 32'd6, 32'd0, 1'b0, 5'd0);
        busy_n = 0;
        for (int i = 0; i < MC + 1; i++) begin
            #1 if (ex_busy) busy_n++;
            step;
            if (i == 0) begin fwdA_sel = 1; fwd_mem = 32'd99; rdat2 = 32'd1000; end
        end
        in_valid = 0;
        chk("mul_busy_cycles", busy_n, MC);
        chk("mul_res", ALUOut, 32'd42);
        chk("mul_valid", {31'b0, out_valid}, 32'd1);
        put(4'd12, 32'd3, 32'd5, 32'd0, 1'b0, 5'd0);
        repeat (MC) step;
        mem_stall = 1;
        #1 chk("mul_stall_busy", {31'b0, ex_busy}, 32'd1);
        step;
        step;
        chk("mul_stall_valid", {31'b0, out_valid}, 32'd0);
        chk("mul_stall_busy2", {31'b0, ex_busy}, 32'd1);
        mem_stall = 0;
        #1 chk("mul_release_busy", {31'b0, ex_busy}, 32'd0);
        step;
        in_valid = 0;
        chk("mul_stall_res", ALUOut, 32'd15);
        chk("mul_stall_ok", {31'b0, out_valid}, 32'd1);
        put(4'd12, 32'd4, 32'd5, 32'd0, 1'b0, 5'd0);
        step;
        step;
        flush = 1; in_valid = 0;
        step;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_busy", {31'b0, ex_busy}, 32'd0);
        flush = 0;
        put(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0);
        step;
        chk("after_flush", ALUOut, 32'd5);
        chk("after_flush_v", {31'b0, out_valid}, 32'd1);
        flush = 1;
        step;
        chk("flush_latch", {31'b0, out_valid}, 32'd0);
        flush = 0;
        put(4'd12, 32'd9, 32'd9, 32'd0, 1'b0, 5'd0);
        step;
        step;
        in_valid = 0;
        RST = 1;
        #1;
        chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_alu", ALUOut, 32'd0);
        chk("rst_async_busy", {31'b0, ex_busy}, 32'd0);
        step;
        RST = 0;
        put(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0);
        step;
        chk("after_rst", ALUOut, 32'd5);
        in_valid = 0;
        step;
        step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
